// File: rtl/data_sram_ctrl_if.sv
// Bundle of MEM-stage request, pipeline status and data SRAM-like bus signals.
// Pure wiring, no latency.
// The master modport is the sequencer; slave is the pipeline + bus side.
// Ports: mem_* request from MEM stage, pipe_stall/stall_req stall handshake,
//        rdata_out/rdata_valid/addr_err results, data_* two-phase bus.
interface data_sram_ctrl_if;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        pipe_stall;
  logic        stall_req;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic        addr_err;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    input  mem_req, mem_wr, mem_size, mem_unsigned, mem_addr, mem_wdata, pipe_stall,
    input  data_addr_ok, data_data_ok, data_rdata,
    output stall_req, rdata_out, rdata_valid, addr_err,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata
  );

  modport slave (
    output mem_req, mem_wr, mem_size, mem_unsigned, mem_addr, mem_wdata, pipe_stall,
    output data_addr_ok, data_data_ok, data_rdata,
    input  stall_req, rdata_out, rdata_valid, addr_err,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata
  );
endinterface

// File: rtl/data_sram_ctrl.sv
// Turns one MEM-stage load/store into an address-phase + data-phase bus transaction.
// Latency: accept -> ADDR -> DATA -> DONE, 3 cycles minimum, +1 per addr_ok/data_ok wait.
// Backpressure: stalls the pipeline while in flight; holds the result in DONE under pipe_stall.
// Ports: clk, rst (async, active-high); bus = data_sram_ctrl_if.master carrying the
//        MEM request, stall handshake, extended load result and the data SRAM-like bus.
module data_sram_ctrl (
  input  logic             clk,
  input  logic             rst,
  data_sram_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q;
  logic        data_req_q;
  logic        data_wr_q;
  logic [3:0]  data_wstrb_q;
  logic [31:0] data_addr_q;
  logic [31:0] data_wdata_q;
  logic [31:0] rdata_out_q;
  logic        rdata_valid_q;
  logic [1:0]  size_q;
  logic        unsigned_q;

  logic        misaligned_d;
  logic        accept_d;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d;
  logic [7:0]  lane_b_d;
  logic [15:0] lane_h_d;
  logic [31:0] load_ext_d;

  always_comb begin
    misaligned_d = 1'b0;
    wstrb_d      = 4'b1111;
    wdata_d      = bus.mem_wdata;
    case (bus.mem_size)
      2'b00: begin
        wstrb_d = 4'b0001 << bus.mem_addr[1:0];
        wdata_d = {4{bus.mem_wdata[7:0]}};
      end
      2'b01: begin
        misaligned_d = bus.mem_addr[0];
        wstrb_d      = 4'b0011 << {bus.mem_addr[1], 1'b0};
        wdata_d      = {2{bus.mem_wdata[15:0]}};
      end
      default: misaligned_d = |bus.mem_addr[1:0];  // size 11 behaves as word
    endcase
    accept_d = (state_q == IDLE) && bus.mem_req && !misaligned_d;
  end

  // Load lane selection uses the address latched at accept, not the live one.
  always_comb begin
    lane_b_d = bus.data_rdata[7:0];
    case (data_addr_q[1:0])
      2'b01:   lane_b_d = bus.data_rdata[15:8];
      2'b10:   lane_b_d = bus.data_rdata[23:16];
      2'b11:   lane_b_d = bus.data_rdata[31:24];
      default: lane_b_d = bus.data_rdata[7:0];
    endcase
    lane_h_d = data_addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (size_q)
      2'b00:   load_ext_d = {{24{~unsigned_q & lane_b_d[7]}}, lane_b_d};
      2'b01:   load_ext_d = {{16{~unsigned_q & lane_h_d[15]}}, lane_h_d};
      default: load_ext_d = bus.data_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      data_req_q    <= 1'b0;
      data_wr_q     <= 1'b0;
      data_wstrb_q  <= 4'b0000;
      data_addr_q   <= 32'h0;
      data_wdata_q  <= 32'h0;
      rdata_out_q   <= 32'h0;
      rdata_valid_q <= 1'b0;
      size_q        <= 2'b00;
      unsigned_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            state_q      <= ADDR;
            data_req_q   <= 1'b1;
            data_wr_q    <= bus.mem_wr;
            data_wstrb_q <= bus.mem_wr ? wstrb_d : 4'b0000;
            data_addr_q  <= bus.mem_addr;
            data_wdata_q <= wdata_d;
            size_q       <= bus.mem_size;
            unsigned_q   <= bus.mem_unsigned;
          end
        end
        ADDR: begin
          if (bus.data_addr_ok) begin
            state_q    <= DATA;
            data_req_q <= 1'b0;
          end
        end
        DATA: begin
          if (bus.data_data_ok) begin
            state_q       <= DONE;
            rdata_out_q   <= data_wr_q ? 32'h0 : load_ext_d;
            rdata_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // mem_req is ignored here so a held instruction is never reissued.
          if (!bus.pipe_stall) begin
            state_q       <= IDLE;
            rdata_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_req   = accept_d || (state_q == ADDR) || (state_q == DATA);
  assign bus.addr_err    = (state_q == IDLE) && bus.mem_req && misaligned_d;
  assign bus.data_req    = data_req_q;
  assign bus.data_wr     = data_wr_q;
  assign bus.data_wstrb  = data_wstrb_q;
  assign bus.data_addr   = data_addr_q;
  assign bus.data_wdata  = data_wdata_q;
  assign bus.rdata_out   = rdata_out_q;
  assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Directed bench for data_sram_ctrl: reset, word/sub-word loads, stores,
// wait states with result hold, misalignment, back-to-back and mid-transaction reset.
module tb_data_sram_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  data_sram_ctrl_if bif ();
  data_sram_ctrl dut (.clk(clk), .rst(rst), .bus(bif));

  typedef struct {
    logic [31:0] res;
    int          nreq;
    bit          unstable;
    bit          held_bad;
    int          stall_cyc;
    int          lat;
    int          ndone;
    bit          timeout;
    logic        wr0;
    logic [3:0]  strb0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
  } obs_t;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs;
    bif.mem_req      = 1'b0;
    bif.mem_wr       = 1'b0;
    bif.mem_size     = 2'b00;
    bif.mem_unsigned = 1'b0;
    bif.mem_addr     = 32'h0;
    bif.mem_wdata    = 32'h0;
    bif.pipe_stall   = 1'b0;
    bif.data_addr_ok = 1'b0;
    bif.data_data_ok = 1'b0;
    bif.data_rdata   = 32'h0;
  endtask

  // Drives one access from an IDLE cycle start until DONE is released.
  // aw/dw = extra wait cycles before addr_ok/data_ok; hold = DONE cycles under pipe_stall.
  // noise drives data_ok in ADDR and DONE (with corrupted rdata) where it must be ignored.
  task automatic run_access(input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdata, input int aw, input int dw,
                            input int hold, input bit noise, output obs_t o);
    bit acc = 0;
    bit fin = 0;
    int dcnt = 0;
    o = '{res: 32'h0, nreq: 0, unstable: 0, held_bad: 0, stall_cyc: 0, lat: -1,
          ndone: 0, timeout: 0, wr0: 1'b0, strb0: 4'h0, addr0: 32'h0, wdata0: 32'h0};
    bif.mem_req = 1'b1; bif.mem_wr = wr; bif.mem_size = size; bif.mem_unsigned = uns;
    bif.mem_addr = addr; bif.mem_wdata = wdata;
    for (int c = 0; c < 200 && !fin; c++) begin
      bif.data_addr_ok = 1'b0; bif.data_data_ok = 1'b0; bif.pipe_stall = 1'b0;
      bif.data_rdata = rdata;
      if (bif.data_req) begin
        o.nreq++;
        if (o.nreq == 1) begin
          o.wr0 = bif.data_wr; o.strb0 = bif.data_wstrb;
          o.addr0 = bif.data_addr; o.wdata0 = bif.data_wdata;
        end else if (bif.data_wr !== o.wr0 || bif.data_wstrb !== o.strb0 ||
                     bif.data_addr !== o.addr0 || bif.data_wdata !== o.wdata0) begin
          o.unstable = 1;
        end
        bif.data_addr_ok = (o.nreq > aw);
        if (noise && !bif.data_addr_ok) bif.data_data_ok = 1'b1;
      end
      if (acc) begin
        dcnt++;
        bif.data_data_ok = (dcnt > dw);
      end
      if (bif.rdata_valid) begin
        if (o.ndone == 0) begin
          o.res = bif.rdata_out; o.lat = c;
        end else if (bif.rdata_out !== o.res) begin
          o.held_bad = 1;
        end
        bif.pipe_stall = (o.ndone < hold);
        o.ndone++;
        if (noise) begin
          bif.data_data_ok = 1'b1; bif.data_rdata = ~rdata;
        end
        if (!bif.pipe_stall) fin = 1;
      end
      #1;
      if (bif.stall_req) o.stall_cyc++;
      if (acc && bif.data_data_ok) acc = 0;
      if (bif.data_req && bif.data_addr_ok) acc = 1;
      tick();
    end
    o.timeout = !fin;
    idle_inputs();
  endtask

  task automatic test_reset;
    idle_inputs();
    #1 rst = 1'b1;
    tick(); tick();
    total++; if (bif.data_req !== 1'b0) begin bad++; $display("FAIL rst_data_req got=%b exp=0", bif.data_req); end
    total++; if (bif.data_wr !== 1'b0) begin bad++; $display("FAIL rst_data_wr got=%b exp=0", bif.data_wr); end
    total++; if (bif.data_wstrb !== 4'h0) begin bad++; $display("FAIL rst_wstrb got=%h exp=0", bif.data_wstrb); end
    total++; if (bif.data_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bif.data_addr); end
    total++; if (bif.data_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", bif.data_wdata); end
    total++; if (bif.rdata_out !== 32'h0) begin bad++; $display("FAIL rst_rdata_out got=%h exp=0", bif.rdata_out); end
    total++; if (bif.rdata_valid !== 1'b0) begin bad++; $display("FAIL rst_rdata_valid got=%b exp=0", bif.rdata_valid); end
    total++; if (bif.stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall_req got=%b exp=0", bif.stall_req); end
    total++; if (bif.addr_err !== 1'b0) begin bad++; $display("FAIL rst_addr_err got=%b exp=0", bif.addr_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_word;
    obs_t o;
    run_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 0, 1'b0, o);
    total++; if (o.res !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_rdata got=%h exp=deadbeef", o.res); end
    total++; if (o.lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", o.lat); end
    total++; if (o.nreq !== 1) begin bad++; $display("FAIL lw_req_cycles got=%0d exp=1", o.nreq); end
    total++; if (o.stall_cyc !== 3) begin bad++; $display("FAIL lw_stall_cycles got=%0d exp=3", o.stall_cyc); end
    total++; if (o.strb0 !== 4'b0000) begin bad++; $display("FAIL lw_wstrb got=%b exp=0000", o.strb0); end
    total++; if (o.wr0 !== 1'b0) begin bad++; $display("FAIL lw_wr got=%b exp=0", o.wr0); end
    total++; if (o.addr0 !== 32'h100) begin bad++; $display("FAIL lw_addr got=%h exp=100", o.addr0); end
    total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL lw_timeout got=%b exp=0", o.timeout); end
    #1;
    total++; if (bif.rdata_valid !== 1'b0) begin bad++; $display("FAIL lw_valid_cleared got=%b exp=0", bif.rdata_valid); end
    total++; if (bif.stall_req !== 1'b0) begin bad++; $display("FAIL lw_idle_stall got=%b exp=0", bif.stall_req); end
  endtask

  task automatic test_store_byte;
    obs_t o;
    run_access(1'b1, 2'b00, 1'b0, 32'h203, 32'h000000A5, 32'h12345678, 0, 0, 0, 1'b0, o);
    total++; if (o.strb0 !== 4'b1000) begin bad++; $display("FAIL sb_wstrb got=%b exp=1000", o.strb0); end
    total++; if (o.wdata0 !== 32'hA5A5A5A5) begin bad++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", o.wdata0); end
    total++; if (o.wr0 !== 1'b1) begin bad++; $display("FAIL sb_wr got=%b exp=1", o.wr0); end
    total++; if (o.addr0 !== 32'h203) begin bad++; $display("FAIL sb_addr got=%h exp=203", o.addr0); end
    total++; if (o.res !== 32'h0) begin bad++; $display("FAIL sb_rdata got=%h exp=0", o.res); end
    total++; if (o.lat !== 3) begin bad++; $display("FAIL sb_latency got=%0d exp=3", o.lat); end
  endtask

  task automatic test_subword_loads;
    logic [1:0]  sz  [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
    logic        un  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  off [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] exp [5] = '{32'h0000007F, 32'hFFFFFFF1, 32'h00000080, 32'hFFFF80F1, 32'h00007F02};
    obs_t o;
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, sz[i], un[i], 32'h300 | {30'h0, off[i]}, 32'hFFFFFFFF, 32'h80F17F02, 0, 0, 0, 1'b0, o);
      total++; if (o.res !== exp[i]) begin bad++; $display("FAIL subword_%0d got=%h exp=%h", i, o.res, exp[i]); end
      total++; if (o.strb0 !== 4'b0000) begin bad++; $display("FAIL subword_wstrb_%0d got=%b exp=0000", i, o.strb0); end
    end
  endtask

  task automatic test_wait_hold;
    obs_t o;
    run_access(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'hCAFEF00D, 3, 2, 4, 1'b1, o);
    total++; if (o.res !== 32'hCAFEF00D) begin bad++; $display("FAIL wait_rdata got=%h exp=cafef00d", o.res); end
    total++; if (o.nreq !== 4) begin bad++; $display("FAIL wait_req_cycles got=%0d exp=4", o.nreq); end
    total++; if (o.unstable !== 1'b0) begin bad++; $display("FAIL wait_bus_stable got=%b exp=0", o.unstable); end
    total++; if (o.held_bad !== 1'b0) begin bad++; $display("FAIL wait_hold got=%b exp=0", o.held_bad); end
    total++; if (o.lat !== 8) begin bad++; $display("FAIL wait_latency got=%0d exp=8", o.lat); end
    total++; if (o.stall_cyc !== 8) begin bad++; $display("FAIL wait_stall_cycles got=%0d exp=8", o.stall_cyc); end
    total++; if (o.ndone !== 5) begin bad++; $display("FAIL wait_done_cycles got=%0d exp=5", o.ndone); end
    total++; if (o.timeout !== 1'b0) begin bad++; $display("FAIL wait_timeout got=%b exp=0", o.timeout); end
  endtask

  task automatic test_misaligned;
    logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
    logic [31:0] ad [3] = '{32'h102, 32'h101, 32'h103};
    for (int i = 0; i < 3; i++) begin
      bif.mem_req = 1'b1; bif.mem_wr = 1'b0; bif.mem_size = sz[i]; bif.mem_addr = ad[i];
      for (int c = 0; c < 3; c++) begin
        #1;
        total++; if (bif.addr_err !== 1'b1) begin bad++; $display("FAIL mis_addr_err_%0d got=%b exp=1", i, bif.addr_err); end
        total++; if (bif.stall_req !== 1'b0) begin bad++; $display("FAIL mis_stall_%0d got=%b exp=0", i, bif.stall_req); end
        total++; if (bif.data_req !== 1'b0) begin bad++; $display("FAIL mis_data_req_%0d got=%b exp=0", i, bif.data_req); end
        tick();
      end
    end
    idle_inputs();
    #1;
    total++; if (bif.addr_err !== 1'b0) begin bad++; $display("FAIL mis_clear got=%b exp=0", bif.addr_err); end
    tick();
  endtask

  task automatic test_back_to_back;
    obs_t o;
    run_access(1'b1, 2'b01, 1'b0, 32'h402, 32'h1234BEEF, 32'h0, 0, 0, 0, 1'b0, o);
    total++; if (o.strb0 !== 4'b1100) begin bad++; $display("FAIL b2b_sh_wstrb got=%b exp=1100", o.strb0); end
    total++; if (o.wdata0 !== 32'hBEEFBEEF) begin bad++; $display("FAIL b2b_sh_wdata got=%h exp=beefbeef", o.wdata0); end
    run_access(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h0BADF00D, 0, 0, 0, 1'b0, o);
    total++; if (o.lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", o.lat); end
    total++; if (o.stall_cyc !== 3) begin bad++; $display("FAIL b2b_stall_cycles got=%0d exp=3", o.stall_cyc); end
    total++; if (o.res !== 32'h0BADF00D) begin bad++; $display("FAIL b2b_rdata got=%h exp=0badf00d", o.res); end
  endtask

  task automatic test_reset_mid;
    obs_t o;
    // Reset while in ADDR: data_req must drop without a clock edge.
    bif.mem_req = 1'b1; bif.mem_size = 2'b10; bif.mem_addr = 32'h600;
    tick();
    total++; if (bif.data_req !== 1'b1) begin bad++; $display("FAIL rstaddr_pre_req got=%b exp=1", bif.data_req); end
    rst = 1'b1; #1;
    total++; if (bif.data_req !== 1'b0) begin bad++; $display("FAIL rstaddr_req got=%b exp=0", bif.data_req); end
    rst = 1'b0; idle_inputs();
    tick();
    // Reset while in DATA, waiting for data_ok.
    bif.mem_req = 1'b1; bif.mem_size = 2'b10; bif.mem_addr = 32'h700;
    tick();
    bif.data_addr_ok = 1'b1;
    tick();
    bif.data_addr_ok = 1'b0;
    #1;
    total++; if (bif.stall_req !== 1'b1) begin bad++; $display("FAIL rstdata_pre_stall got=%b exp=1", bif.stall_req); end
    rst = 1'b1; #1;
    bif.mem_req = 1'b0; #1;
    total++; if (bif.data_req !== 1'b0) begin bad++; $display("FAIL rstdata_req got=%b exp=0", bif.data_req); end
    total++; if (bif.rdata_valid !== 1'b0) begin bad++; $display("FAIL rstdata_valid got=%b exp=0", bif.rdata_valid); end
    total++; if (bif.stall_req !== 1'b0) begin bad++; $display("FAIL rstdata_stall got=%b exp=0", bif.stall_req); end
    tick();
    rst = 1'b0;
    tick();
    run_access(1'b0, 2'b00, 1'b1, 32'h800, 32'h0, 32'h000000C3, 0, 0, 0, 1'b0, o);
    total++; if (o.lat !== 3) begin bad++; $display("FAIL rstdata_after_latency got=%0d exp=3", o.lat); end
    total++; if (o.res !== 32'h000000C3) begin bad++; $display("FAIL rstdata_after_rdata got=%h exp=c3", o.res); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_subword_loads();
    test_wait_hold();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
